// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
// Shared types and constants for the branch resolve unit.
//   bru_pred_rec_t : one prediction record per fetched instruction
//   bru_state_t    : resolve FSM states (RUN, REDIRECT)
//   INSTR_BYTES    : fall-through PC increment
// Address fields are held at the maximum supported width; the top level
// truncates them to its ADDR_WIDTH.
// -----------------------------------------------------------------------------
package bru_pkg;

    localparam int unsigned BRU_MAX_ADDR_WIDTH = 64;
    localparam int unsigned INSTR_BYTES        = 4;

    typedef struct packed {
        logic [BRU_MAX_ADDR_WIDTH-1:0] pc;
        logic                          pred_taken;
        logic [BRU_MAX_ADDR_WIDTH-1:0] pred_target;
        logic [1:0]                    way;
    } bru_pred_rec_t;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } bru_state_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// -----------------------------------------------------------------------------
// bru_pred_fifo
// Synchronous in-order FIFO of prediction records.
//   i_clk, i_arst : clock, synchronous active-high reset
//   i_clear       : empty the queue this cycle (overrides push and pop)
//   i_push/i_wdata: enqueue; accepted when not full or when a pop is
//                   accepted in the same cycle
//   i_pop/o_rdata : dequeue; o_rdata is the current head (combinational)
//   o_full, o_empty, o_count : occupancy
// -----------------------------------------------------------------------------
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  bru_pred_rec_t            i_wdata,
    input  logic                     i_pop,
    output bru_pred_rec_t            o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bru_pred_rec_t    mem_q [DEPTH];
    bru_pred_rec_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pop_ok;
    logic push_ok;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Execute-side branch resolution. Holds one prediction record per fetched
// instruction, compares the queue head against the actual outcome when an
// instruction leaves execute, and issues a registered redirect to fetch and a
// registered training update to the predictor.
//   Fetch side : i_fetch_valid, i_stall_fetch, i_pred_taken, i_pred_way,
//                i_pred_pc, i_pred_target, o_full
//   Exec side  : i_exec_valid, i_exec_branch, i_exec_taken, i_exec_target
//   Control    : i_clk, i_arst (sync, active-high), i_flush
//   Redirect   : o_redirect, o_redirect_pc
//   Training   : o_bp_update, o_bp_taken, o_bp_way, o_bp_pc, o_bp_target
//   Status     : o_overflow, o_underflow (sticky until reset)
//   Optional   : o_branch_cnt, o_mispred_cnt when BRU_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_fetch_valid,
    input  logic                  i_stall_fetch,
    input  logic                  i_pred_taken,
    input  logic [1:0]            i_pred_way,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    input  logic [ADDR_WIDTH-1:0] i_pred_target,
    input  logic                  i_exec_valid,
    input  logic                  i_exec_branch,
    input  logic                  i_exec_taken,
    input  logic [ADDR_WIDTH-1:0] i_exec_target,
    input  logic                  i_flush,
    output logic                  o_full,
    output logic                  o_redirect,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_bp_update,
    output logic                  o_bp_taken,
    output logic [1:0]            o_bp_way,
    output logic [ADDR_WIDTH-1:0] o_bp_pc,
    output logic [ADDR_WIDTH-1:0] o_bp_target,
    output logic                  o_overflow,
`ifdef BRU_PERF_CNT_EN
    output logic                  o_underflow,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_mispred_cnt
`else
    output logic                  o_underflow
`endif
);

    bru_state_t state_q, state_d;

    bru_pred_rec_t         push_rec;
    bru_pred_rec_t         head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_clear;

    logic                  push_req, pop_req;
    logic                  do_push, do_pop;
    logic                  mispred;
    logic [ADDR_WIDTH-1:0] head_pc, head_target, fix_pc;

    logic                  redirect_q, redirect_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  bp_update_q, bp_update_d;
    logic                  bp_taken_q, bp_taken_d;
    logic [1:0]            bp_way_q, bp_way_d;
    logic [ADDR_WIDTH-1:0] bp_pc_q, bp_pc_d;
    logic [ADDR_WIDTH-1:0] bp_target_q, bp_target_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Requests only count in RUN; during REDIRECT everything is wrong-path.
    assign push_req = i_fetch_valid & ~i_stall_fetch & (state_q == RUN);
    assign pop_req  = i_exec_valid & (state_q == RUN);
    assign do_pop   = pop_req & ~fifo_empty;
    assign do_push  = push_req & (~fifo_full | do_pop);

    assign fifo_clear = i_flush | (state_q == REDIRECT);

    always_comb begin
        push_rec             = '0;
        push_rec.pc          = BRU_MAX_ADDR_WIDTH'(i_pred_pc);
        push_rec.pred_taken  = i_pred_taken;
        push_rec.pred_target = BRU_MAX_ADDR_WIDTH'(i_pred_target);
        push_rec.way         = i_pred_way;
    end

    bru_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_clear (fifo_clear),
        .i_push  (push_req),
        .i_wdata (push_rec),
        .i_pop   (pop_req),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign o_full = fifo_full;

    assign head_pc     = head.pc[ADDR_WIDTH-1:0];
    assign head_target = head.pred_target[ADDR_WIDTH-1:0];

    always_comb begin
        mispred = 1'b0;
        if (do_pop) begin
            if (i_exec_branch) begin
                mispred = (head.pred_taken != i_exec_taken) |
                          (head.pred_taken & i_exec_taken &
                           (head_target != i_exec_target));
            end else begin
                // Non-branch predicted taken: BTB aliased onto this PC.
                mispred = head.pred_taken;
            end
        end
    end

    assign fix_pc = (i_exec_taken & i_exec_branch) ? i_exec_target
                  : head_pc + ADDR_WIDTH'(INSTR_BYTES);

    // The redirect pulse is its own register rather than decoded from the
    // state, so a mispredict coincident with i_flush still redirects while
    // the flush forces the FSM to stay in RUN.
    always_comb begin
        state_d       = state_q;
        redirect_d    = mispred;
        redirect_pc_d = redirect_pc_q;
        bp_update_d   = do_pop & i_exec_branch;
        bp_taken_d    = bp_taken_q;
        bp_way_d      = bp_way_q;
        bp_pc_d       = bp_pc_q;
        bp_target_d   = bp_target_q;
        overflow_d    = overflow_q | (push_req & fifo_full & ~do_pop);
        underflow_d   = underflow_q | (pop_req & fifo_empty);

        case (state_q)
            RUN:      state_d = mispred ? REDIRECT : RUN;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (i_flush) begin
            state_d = RUN;
        end

        if (mispred) begin
            redirect_pc_d = fix_pc;
        end
        if (do_pop & i_exec_branch) begin
            bp_taken_d  = i_exec_taken;
            bp_way_d    = head.way;
            bp_pc_d     = head_pc;
            bp_target_d = i_exec_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            bp_update_q   <= 1'b0;
            bp_taken_q    <= 1'b0;
            bp_way_q      <= '0;
            bp_pc_q       <= '0;
            bp_target_q   <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            bp_update_q   <= bp_update_d;
            bp_taken_q    <= bp_taken_d;
            bp_way_q      <= bp_way_d;
            bp_pc_q       <= bp_pc_d;
            bp_target_q   <= bp_target_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_bp_update   = bp_update_q;
    assign o_bp_taken    = bp_taken_q;
    assign o_bp_way      = bp_way_q;
    assign o_bp_pc       = bp_pc_q;
    assign o_bp_target   = bp_target_q;
    assign o_overflow    = overflow_q;
    assign o_underflow   = underflow_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (do_pop & i_exec_branch) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispred) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

    // Occupancy is only consumed through o_full at this level.
    logic unused_ok;
    assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int unsigned AW = 64;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_fetch_valid, i_stall_fetch, i_pred_taken;
    logic [1:0]    i_pred_way;
    logic [AW-1:0] i_pred_pc, i_pred_target;
    logic          i_exec_valid, i_exec_branch, i_exec_taken;
    logic [AW-1:0] i_exec_target;
    logic          i_flush;
    logic          o_full, o_redirect, o_bp_update, o_bp_taken;
    logic [AW-1:0] o_redirect_pc, o_bp_pc, o_bp_target;
    logic [1:0]    o_bp_way;
    logic          o_overflow, o_underflow;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]   o_branch_cnt, o_mispred_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    branch_resolve_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (4),
        .CNT_WIDTH  (32)
    ) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_fetch_valid (i_fetch_valid),
        .i_stall_fetch (i_stall_fetch),
        .i_pred_taken  (i_pred_taken),
        .i_pred_way    (i_pred_way),
        .i_pred_pc     (i_pred_pc),
        .i_pred_target (i_pred_target),
        .i_exec_valid  (i_exec_valid),
        .i_exec_branch (i_exec_branch),
        .i_exec_taken  (i_exec_taken),
        .i_exec_target (i_exec_target),
        .i_flush       (i_flush),
        .o_full        (o_full),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_bp_update   (o_bp_update),
        .o_bp_taken    (o_bp_taken),
        .o_bp_way      (o_bp_way),
        .o_bp_pc       (o_bp_pc),
        .o_bp_target   (o_bp_target),
        .o_overflow    (o_overflow),
`ifdef BRU_PERF_CNT_EN
        .o_underflow   (o_underflow),
        .o_branch_cnt  (o_branch_cnt),
        .o_mispred_cnt (o_mispred_cnt)
`else
        .o_underflow   (o_underflow)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_fetch_valid = 1'b0;
        i_stall_fetch = 1'b0;
        i_pred_taken  = 1'b0;
        i_pred_way    = 2'd0;
        i_pred_pc     = '0;
        i_pred_target = '0;
        i_exec_valid  = 1'b0;
        i_exec_branch = 1'b0;
        i_exec_taken  = 1'b0;
        i_exec_target = '0;
        i_flush       = 1'b0;
    endtask

    task automatic set_push(input logic [AW-1:0] pc, input logic tk,
                            input logic [AW-1:0] tgt, input logic [1:0] way);
        i_fetch_valid = 1'b1;
        i_pred_pc     = pc;
        i_pred_taken  = tk;
        i_pred_target = tgt;
        i_pred_way    = way;
    endtask

    task automatic set_pop(input logic br, input logic tk, input logic [AW-1:0] tgt);
        i_exec_valid  = 1'b1;
        i_exec_branch = br;
        i_exec_taken  = tk;
        i_exec_target = tgt;
    endtask

    task automatic push_one(input logic [AW-1:0] pc, input logic tk,
                            input logic [AW-1:0] tgt, input logic [1:0] way);
        set_push(pc, tk, tgt, way);
        step();
        clear_inputs();
    endtask

    task automatic pop_one(input logic br, input logic tk, input logic [AW-1:0] tgt);
        set_pop(br, tk, tgt);
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_arst = 1'b1;
        step();
        step();
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL reset_redirect: got %0h want 0", o_redirect); end
        checks++; if (o_redirect_pc !== '0) begin fails++; $display("FAIL reset_redirect_pc: got %0h want 0", o_redirect_pc); end
        checks++; if (o_bp_update !== 1'b0) begin fails++; $display("FAIL reset_bp_update: got %0h want 0", o_bp_update); end
        checks++; if (o_bp_pc !== '0) begin fails++; $display("FAIL reset_bp_pc: got %0h want 0", o_bp_pc); end
        checks++; if (o_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0h want 0", o_full); end
        checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0h want 0", o_overflow); end
        checks++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %0h want 0", o_underflow); end
`ifdef BRU_PERF_CNT_EN
        checks++; if (o_branch_cnt !== 32'd0) begin fails++; $display("FAIL reset_branch_cnt: got %0h want 0", o_branch_cnt); end
        checks++; if (o_mispred_cnt !== 32'd0) begin fails++; $display("FAIL reset_mispred_cnt: got %0h want 0", o_mispred_cnt); end
`endif
        i_arst = 1'b0;
        step();
    endtask

    task automatic test_correct_not_taken();
        push_one(64'h100, 1'b0, 64'h0, 2'd0);
        pop_one(1'b1, 1'b0, 64'h104);
        checks++; if (o_bp_update !== 1'b1) begin fails++; $display("FAIL nt_bp_update: got %0h want 1", o_bp_update); end
        checks++; if (o_bp_taken !== 1'b0) begin fails++; $display("FAIL nt_bp_taken: got %0h want 0", o_bp_taken); end
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL nt_redirect: got %0h want 0", o_redirect); end
        checks++; if (o_bp_pc !== 64'h100) begin fails++; $display("FAIL nt_bp_pc: got %0h want 100", o_bp_pc); end
        step();
        checks++; if (o_bp_update !== 1'b0) begin fails++; $display("FAIL nt_bp_pulse: got %0h want 0", o_bp_update); end
        checks++; if (o_bp_pc !== 64'h100) begin fails++; $display("FAIL nt_bp_pc_hold: got %0h want 100", o_bp_pc); end
    endtask

    task automatic test_target_mispredict();
        push_one(64'h400, 1'b1, 64'h500, 2'd2);
        pop_one(1'b1, 1'b1, 64'h600);
        checks++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL tgt_redirect: got %0h want 1", o_redirect); end
        checks++; if (o_redirect_pc !== 64'h600) begin fails++; $display("FAIL tgt_redirect_pc: got %0h want 600", o_redirect_pc); end
        checks++; if (o_bp_way !== 2'd2) begin fails++; $display("FAIL tgt_bp_way: got %0h want 2", o_bp_way); end
        checks++; if (o_bp_taken !== 1'b1) begin fails++; $display("FAIL tgt_bp_taken: got %0h want 1", o_bp_taken); end
        checks++; if (o_bp_target !== 64'h600) begin fails++; $display("FAIL tgt_bp_target: got %0h want 600", o_bp_target); end
        step();
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL tgt_redirect_pulse: got %0h want 0", o_redirect); end
    endtask

    task automatic test_btb_alias();
        push_one(64'h800, 1'b1, 64'h900, 2'd1);
        pop_one(1'b0, 1'b0, 64'h0);
        checks++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL alias_redirect: got %0h want 1", o_redirect); end
        checks++; if (o_redirect_pc !== 64'h804) begin fails++; $display("FAIL alias_redirect_pc: got %0h want 804", o_redirect_pc); end
        checks++; if (o_bp_update !== 1'b0) begin fails++; $display("FAIL alias_bp_update: got %0h want 0", o_bp_update); end
        step();
    endtask

    task automatic test_direction_mispredict();
        push_one(64'h200, 1'b0, 64'h0, 2'd0);
        push_one(64'h300, 1'b0, 64'h0, 2'd0);
        pop_one(1'b1, 1'b1, 64'h340);
        checks++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL dir_redirect: got %0h want 1", o_redirect); end
        checks++; if (o_redirect_pc !== 64'h340) begin fails++; $display("FAIL dir_redirect_pc: got %0h want 340", o_redirect_pc); end
        checks++; if (o_bp_target !== 64'h340) begin fails++; $display("FAIL dir_bp_target: got %0h want 340", o_bp_target); end
        checks++; if (o_bp_pc !== 64'h200) begin fails++; $display("FAIL dir_bp_pc: got %0h want 200", o_bp_pc); end
        // Wrong-path push during the redirect cycle must be discarded.
        push_one(64'h999, 1'b0, 64'h0, 2'd0);
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL dir_redirect_pulse: got %0h want 0", o_redirect); end
    endtask

    // Relies on the queue being empty after test_direction_mispredict.
    task automatic test_full_boundary();
        logic [AW-1:0] exp_pc;
        push_one(64'h1000, 1'b0, 64'h0, 2'd0);
        push_one(64'h1004, 1'b0, 64'h0, 2'd0);
        push_one(64'h1008, 1'b0, 64'h0, 2'd0);
        checks++; if (o_full !== 1'b0) begin fails++; $display("FAIL full_after3: got %0h want 0", o_full); end
        push_one(64'h100C, 1'b0, 64'h0, 2'd0);
        checks++; if (o_full !== 1'b1) begin fails++; $display("FAIL full_after4: got %0h want 1", o_full); end
        set_push(64'h1010, 1'b0, 64'h0, 2'd0);
        set_pop(1'b1, 1'b0, 64'h0);
        step();
        clear_inputs();
        checks++; if (o_full !== 1'b1) begin fails++; $display("FAIL full_pushpop: got %0h want 1", o_full); end
        checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL full_pushpop_ovf: got %0h want 0", o_overflow); end
        checks++; if (o_bp_pc !== 64'h1000) begin fails++; $display("FAIL full_pushpop_pc: got %0h want 1000", o_bp_pc); end
        push_one(64'h1014, 1'b0, 64'h0, 2'd0);
        checks++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL full_overflow: got %0h want 1", o_overflow); end
        checks++; if (o_full !== 1'b1) begin fails++; $display("FAIL full_hold: got %0h want 1", o_full); end
        exp_pc = 64'h1004;
        for (int i = 0; i < 4; i++) begin
            pop_one(1'b1, 1'b0, 64'h0);
            checks++; if (o_bp_pc !== exp_pc) begin fails++; $display("FAIL full_drain_pc%0d: got %0h want %0h", i, o_bp_pc, exp_pc); end
            exp_pc = exp_pc + 64'h4;
        end
        checks++; if (o_full !== 1'b0) begin fails++; $display("FAIL full_drained: got %0h want 0", o_full); end
        checks++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL full_no_underflow: got %0h want 0", o_underflow); end
        checks++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL full_ovf_sticky: got %0h want 1", o_overflow); end
    endtask

    task automatic test_flush();
        push_one(64'h2000, 1'b0, 64'h0, 2'd0);
        set_push(64'h2004, 1'b0, 64'h0, 2'd0);
        i_flush = 1'b1;
        step();
        clear_inputs();
        pop_one(1'b1, 1'b0, 64'h0);
        checks++; if (o_underflow !== 1'b1) begin fails++; $display("FAIL flush_underflow: got %0h want 1", o_underflow); end
        checks++; if (o_bp_update !== 1'b0) begin fails++; $display("FAIL flush_bp_update: got %0h want 0", o_bp_update); end
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL flush_redirect: got %0h want 0", o_redirect); end
        checks++; if (o_bp_pc !== 64'h1010) begin fails++; $display("FAIL flush_bp_pc_hold: got %0h want 1010", o_bp_pc); end
    endtask

    task automatic test_flush_with_mispredict();
        push_one(64'h3000, 1'b0, 64'h0, 2'd0);
        set_pop(1'b1, 1'b1, 64'h3100);
        i_flush = 1'b1;
        step();
        clear_inputs();
        checks++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL fm_redirect: got %0h want 1", o_redirect); end
        checks++; if (o_redirect_pc !== 64'h3100) begin fails++; $display("FAIL fm_redirect_pc: got %0h want 3100", o_redirect_pc); end
        checks++; if (o_bp_update !== 1'b1) begin fails++; $display("FAIL fm_bp_update: got %0h want 1", o_bp_update); end
        // Flush kept the FSM in RUN, so this push is accepted.
        push_one(64'h3200, 1'b0, 64'h0, 2'd0);
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL fm_redirect_pulse: got %0h want 0", o_redirect); end
        pop_one(1'b1, 1'b0, 64'h0);
        checks++; if (o_bp_update !== 1'b1) begin fails++; $display("FAIL fm_run_update: got %0h want 1", o_bp_update); end
        checks++; if (o_bp_pc !== 64'h3200) begin fails++; $display("FAIL fm_run_pc: got %0h want 3200", o_bp_pc); end
    endtask

    task automatic test_reset_mid_redirect();
        push_one(64'h4000, 1'b1, 64'h4100, 2'd3);
        pop_one(1'b0, 1'b0, 64'h0);
        checks++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL rmr_redirect: got %0h want 1", o_redirect); end
        i_arst = 1'b1;
        step();
        i_arst = 1'b0;
        checks++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL rmr_redirect_clr: got %0h want 0", o_redirect); end
        checks++; if (o_redirect_pc !== '0) begin fails++; $display("FAIL rmr_redirect_pc: got %0h want 0", o_redirect_pc); end
        checks++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL rmr_underflow: got %0h want 0", o_underflow); end
        checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL rmr_overflow: got %0h want 0", o_overflow); end
        push_one(64'h5000, 1'b0, 64'h0, 2'd1);
        pop_one(1'b1, 1'b0, 64'h0);
        checks++; if (o_bp_update !== 1'b1) begin fails++; $display("FAIL rmr_run_update: got %0h want 1", o_bp_update); end
        checks++; if (o_bp_way !== 2'd1) begin fails++; $display("FAIL rmr_run_way: got %0h want 1", o_bp_way); end
    endtask

    initial begin
        i_arst = 1'b1;
        clear_inputs();
        test_reset();
        test_correct_not_taken();
        test_target_mispredict();
        test_btb_alias();
        test_direction_mispredict();
        test_full_boundary();
        test_flush();
        test_flush_with_mispredict();
        test_reset_mid_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
